// File: rtl/wb_dma_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_dma_burst_pkg
// Purpose  : Shared types and constants for the Wishbone burst-capture block.
// Revision : 1.0  initial release
// ============================================================================
package wb_dma_burst_pkg;

    localparam int unsigned c_entry_w      = 36;
    localparam int unsigned c_payload_w    = c_entry_w + 1;
    localparam int unsigned c_stat_cnt_lsb = 0;
    localparam int unsigned c_stat_cnt_w   = 5;
    localparam int unsigned c_stat_lvl_lsb = 8;
    localparam int unsigned c_stat_lvl_w   = 8;
    localparam int unsigned c_state_w      = 1;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    function automatic logic [31:0] status_word(input logic [7:0] level,
                                                 input logic [4:0] cnt);
        logic [31:0] w_word;
        w_word = '0;
        w_word[c_stat_lvl_lsb +: c_stat_lvl_w] = level;
        w_word[c_stat_cnt_lsb +: c_stat_cnt_w] = cnt;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_dma_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_dma_burst_fifo
// Purpose  : Synchronous capture FIFO; head output reads as zero when empty.
// Revision : 1.0  initial release
// ============================================================================
module wb_dma_burst_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37,
    localparam int c_aw = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [c_aw:0]    o_level
);

    localparam logic [c_aw:0] c_full_lvl = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full/empty come from registered pointers, so a pop never makes room
    // for a push in the same cycle.
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_level == c_full_lvl);
    assign o_empty   = (o_level == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/wb_dma_burst_capture.sv
`default_nettype none
// ============================================================================
// Module   : wb_dma_burst_capture
// Purpose  : Wishbone classic slave that captures sequential write bursts
//            into a FIFO and replays them on a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module wb_dma_burst_capture
    import wb_dma_burst_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter logic [31:0] ADR_MASK   = 32'hFFFF_0000,
    parameter int          BURST_LEN  = 4,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        dma_brust_valid,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [35:0] m_data,
    output logic        m_last
);

    localparam int         c_lvl_w     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [4:0] c_burst_len = 5'(BURST_LEN);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_beat_cnt;
    logic [31:0]            r_last_adr;
    logic                   r_burst_pulse;
    logic                   w_hit;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_acc_wr;
    logic                   w_acc_rd;
    logic                   w_seq;
    logic                   w_last;
    logic [4:0]             w_cnt_upd;
    logic [c_payload_w-1:0] w_head;
    logic [c_lvl_w-1:0]     w_level;

    assign w_hit    = wbs_cyc_i & wbs_stb_i &
                      ((wbs_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));
    assign w_acc_wr = (r_state == ST_IDLE) & w_hit & wbs_we_i & ~w_full;
    assign w_acc_rd = (r_state == ST_IDLE) & w_hit & ~wbs_we_i;

    // A beat continues the run only when it lands exactly one word past the
    // previous accepted write; anything else restarts the run at one.
    assign w_seq     = (r_beat_cnt != 5'd0) && (wbs_adr_i == r_last_adr + 32'd4);
    assign w_cnt_upd = w_seq ? (r_beat_cnt + 5'd1) : 5'd1;
    assign w_last    = (w_cnt_upd == c_burst_len);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_acc_wr | w_acc_rd) w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = 1'b0;
        wbs_dat_o = '0;
        if (r_state == ST_ACK) begin
            wbs_ack_o = 1'b1;
            wbs_dat_o = status_word(8'(w_level), r_beat_cnt);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_beat_cnt    <= 5'd0;
            r_last_adr    <= 32'd0;
            r_burst_pulse <= 1'b0;
        end else begin
            r_burst_pulse <= 1'b0;
            if (w_acc_wr) begin
                r_last_adr    <= wbs_adr_i;
                r_beat_cnt    <= w_last ? 5'd0 : w_cnt_upd;
                r_burst_pulse <= w_last;
            end
        end
    end

    wb_dma_burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_payload_w)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_acc_wr),
        .i_data  ({w_last, wbs_sel_i, wbs_dat_i}),
        .i_pop   (m_valid & m_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign dma_brust_valid = r_burst_pulse;
    assign m_valid         = ~w_empty;
    assign m_data          = w_head[c_entry_w-1:0];
    assign m_last          = w_head[c_entry_w];

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_burst_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_dma_burst_capture
// Purpose  : Self-checking bench for wb_dma_burst_capture against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_dma_burst_capture;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] MASK  = 32'hFFFF_0000;
    localparam int          BURST = 4;
    localparam int          MAXW  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, dat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        pulse;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [35:0] m_data;
    logic        m_last;

    logic        w2_cyc = 1'b0, w2_stb = 1'b0, w2_we = 1'b0;
    logic [3:0]  w2_sel = '0;
    logic [31:0] w2_adr = '0, w2_dat = '0;
    logic        w2_ack, w2_pulse, w2_mvalid, w2_mlast;
    logic        w2_mready = 1'b0;
    logic [31:0] w2_dat_o;
    logic [35:0] w2_mdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected stream contents plus the current run state.
    logic [36:0] exp_q[$];
    logic [36:0] obs_q[$];
    logic [4:0]  mdl_cnt = '0;
    logic [31:0] mdl_last_adr = '0;

    always #5 clk = ~clk;

    wb_dma_burst_capture u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .dma_brust_valid(pulse), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    wb_dma_burst_capture #(.ADR_MASK(32'h0000_0000)) u_dut_wrap (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(w2_cyc), .wbs_stb_i(w2_stb), .wbs_we_i(w2_we), .wbs_sel_i(w2_sel),
        .wbs_adr_i(w2_adr), .wbs_dat_i(w2_dat), .wbs_ack_o(w2_ack), .wbs_dat_o(w2_dat_o),
        .dma_brust_valid(w2_pulse), .m_valid(w2_mvalid), .m_ready(w2_mready),
        .m_data(w2_mdata), .m_last(w2_mlast)
    );

    task automatic model_write(input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, output logic burst_done);
        int run;
        if (mdl_cnt != 0 && a == mdl_last_adr + 32'd4) run = int'(mdl_cnt) + 1;
        else run = 1;
        burst_done = (run == BURST);
        mdl_cnt = burst_done ? 5'd0 : 5'(run);
        mdl_last_adr = a;
        exp_q.push_back({burst_done, s, d});
    endtask

    function automatic logic [31:0] model_status();
        return {16'd0, 8'(exp_q.size()), 3'd0, mdl_cnt};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        mdl_cnt = '0;
        mdl_last_adr = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic acked, output int lat, output logic p);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
        acked = 1'b0; lat = 0; p = 1'b0;
        for (int i = 1; i <= MAXW; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1; lat = i; p = pulse;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic acked, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        acked = 1'b0; d = '0;
        for (int i = 1; i <= MAXW; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1; d = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    // Pops everything with a random ready pattern, recording what was accepted.
    task automatic drain_stream(input int bound);
        obs_q.delete();
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!m_valid) begin
                m_ready = 1'b0;
                break;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            if (m_ready) obs_q.push_back({m_last, m_data});
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic ok; logic [31:0] st;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
        n_tests++; if (dat_o !== 32'd0) begin n_fail++; $display("FAIL rst_dat_o: got %h want 0", dat_o); end
        n_tests++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse: got %b want 0", pulse); end
        n_tests++; if ({m_valid, m_last, m_data} !== 38'd0) begin
            n_fail++; $display("FAIL rst_stream: got v=%b l=%b d=%h want all 0", m_valid, m_last, m_data);
        end
        bus_read(BASE, ok, st);
        n_tests++; if (!ok || st !== 32'd0) begin n_fail++; $display("FAIL rst_status: ack=%b got %h want 0", ok, st); end
    endtask

    task automatic test_burst();
        logic ok, p, ep; int lat;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_write(BASE + 32'(4 * i), 32'(i + 1), 4'hF, ok, lat, p);
            model_write(BASE + 32'(4 * i), 4'hF, 32'(i + 1), ep);
            n_tests++; if (!ok || lat != 1) begin n_fail++; $display("FAIL burst_ack[%0d]: ack=%b lat=%0d want lat 1", i, ok, lat); end
            n_tests++; if (p !== ep) begin n_fail++; $display("FAIL burst_pulse[%0d]: got %b want %b", i, p, ep); end
        end
        drain_stream(100);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_entry[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_nonseq();
        logic ok, p, ep; int lat; logic [31:0] st, est;
        logic [31:0] addrs [3];
        addrs[0] = BASE; addrs[1] = BASE + 32'h4; addrs[2] = BASE + 32'h20;
        for (int i = 0; i < 3; i++) begin
            bus_write(addrs[i], 32'hA0 + 32'(i), 4'h3, ok, lat, p);
            model_write(addrs[i], 4'h3, 32'hA0 + 32'(i), ep);
            n_tests++; if (!ok || p !== ep) begin n_fail++; $display("FAIL nonseq_beat[%0d]: ack=%b pulse=%b want pulse %b", i, ok, p, ep); end
        end
        bus_read(BASE, ok, st);
        est = model_status();
        n_tests++; if (!ok || st !== est) begin n_fail++; $display("FAIL nonseq_status: got %h want %h", st, est); end
        drain_stream(100);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL nonseq_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nonseq_entry[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic ok, p, ep; int lat, acks; logic [31:0] a, d; logic [36:0] head, want;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = BASE + 32'h100 + 32'(4 * i); d = $urandom;
            bus_write(a, d, 4'hF, ok, lat, p);
            model_write(a, 4'hF, d, ep);
            n_tests++; if (!ok || lat != 1 || p !== ep) begin
                n_fail++; $display("FAIL bp_fill[%0d]: ack=%b lat=%0d pulse=%b want 1/1/%b", i, ok, lat, p, ep);
            end
        end
        a = BASE + 32'h120; d = $urandom;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = 4'h5;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        n_tests++; if (acks != 0) begin n_fail++; $display("FAIL bp_withheld: got %0d acks want 0", acks); end
        head = {m_last, m_data};
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL bp_ack_at_pop: got %b want 0", ack); end
        @(negedge clk);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL bp_ack_after_pop: got %b want 1", ack); end
        p = pulse;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        want = exp_q.pop_front();
        n_tests++; if (head !== want) begin n_fail++; $display("FAIL bp_popped: got %h want %h", head, want); end
        model_write(a, 4'h5, d, ep);
        n_tests++; if (p !== ep) begin n_fail++; $display("FAIL bp_ninth_pulse: got %b want %b", p, ep); end
        drain_stream(200);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_entry[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_nonhit_status();
        logic ok, p, ep; int lat, acks; logic [31:0] st, est; logic [36:0] want;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3001_0000; dat = 32'hDEAD; sel = 4'hF;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_tests++; if (acks != 0 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL nonhit: got %0d acks m_valid=%b want 0/0", acks, m_valid);
        end
        for (int i = 0; i < 4; i++) begin
            bus_write(BASE + 32'h200 + 32'(4 * i), 32'h55 + 32'(i), 4'hC, ok, lat, p);
            model_write(BASE + 32'h200 + 32'(4 * i), 4'hC, 32'h55 + 32'(i), ep);
            n_tests++; if (!ok || p !== ep) begin n_fail++; $display("FAIL st_beat[%0d]: ack=%b pulse=%b want %b", i, ok, p, ep); end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            want = exp_q.pop_front();
            n_tests++; if ({m_last, m_data} !== want) begin n_fail++; $display("FAIL st_pop[%0d]: got %h want %h", i, {m_last, m_data}, want); end
            m_ready = 1'b1;
            @(negedge clk);
        end
        m_ready = 1'b0;
        bus_read(BASE, ok, st);
        est = model_status();
        n_tests++; if (!ok || st !== est) begin n_fail++; $display("FAIL status_two_buffered: got %h want %h", st, est); end
        drain_stream(100);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL st_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic ok, p, ep; int lat; logic [31:0] st;
        for (int i = 0; i < 3; i++) begin
            bus_write(BASE + 32'h300 + 32'(4 * i), $urandom, 4'hF, ok, lat, p);
            model_write(BASE + 32'h300 + 32'(4 * i), 4'hF, 32'h0, ep);
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h30C; dat = 32'h77; sel = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (ack !== 1'b0 || m_valid !== 1'b0 || pulse !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: ack=%b m_valid=%b pulse=%b want 0/0/0", ack, m_valid, pulse);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        model_reset();
        bus_read(BASE, ok, st);
        n_tests++; if (!ok || st !== model_status()) begin n_fail++; $display("FAIL rst_mid_status: got %h want %h", st, model_status()); end
    endtask

    task automatic test_random();
        logic ok, p, ep; int lat; logic [31:0] a, d, st, est; logic [3:0] s;
        for (int chunk = 0; chunk < 8; chunk++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) != 0) a = mdl_last_adr + 32'd4;
                else a = BASE | ($urandom & 32'h0000_FFFC);
                if ((a & MASK) != (BASE & MASK)) a = BASE;
                d = $urandom; s = 4'($urandom);
                bus_write(a, d, s, ok, lat, p);
                model_write(a, s, d, ep);
                n_tests++; if (!ok || lat != 1) begin n_fail++; $display("FAIL rnd_ack: adr=%h ack=%b lat=%0d want lat 1", a, ok, lat); end
                n_tests++; if (p !== ep) begin n_fail++; $display("FAIL rnd_pulse: adr=%h got %b want %b", a, p, ep); end
                if ($urandom_range(0, 3) == 0) begin
                    bus_read(BASE + 32'h40, ok, st);
                    est = model_status();
                    n_tests++; if (!ok || st !== est) begin n_fail++; $display("FAIL rnd_status: got %h want %h", st, est); end
                end
            end
            drain_stream(200);
            n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_entry[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] addrs [4];
        logic [31:0] data  [4];
        logic        got_ack, got_pulse;
        int          pulses;
        addrs[0] = 32'hFFFF_FFF8; addrs[1] = 32'hFFFF_FFFC;
        addrs[2] = 32'h0000_0000; addrs[3] = 32'h0000_0004;
        pulses = 0;
        w2_mready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom;
            @(negedge clk);
            w2_cyc = 1'b1; w2_stb = 1'b1; w2_we = 1'b1; w2_adr = addrs[i]; w2_dat = data[i]; w2_sel = 4'hF;
            got_ack = 1'b0; got_pulse = 1'b0;
            for (int k = 0; k < MAXW; k++) begin
                @(negedge clk);
                if (w2_ack) begin got_ack = 1'b1; got_pulse = w2_pulse; break; end
            end
            w2_cyc = 1'b0; w2_stb = 1'b0; w2_we = 1'b0;
            if (got_pulse) pulses++;
            n_tests++; if (!got_ack || got_pulse !== (i == 3)) begin
                n_fail++; $display("FAIL wrap_beat[%0d]: ack=%b pulse=%b want 1/%b", i, got_ack, got_pulse, (i == 3));
            end
        end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL wrap_pulses: got %0d want 1", pulses); end
        @(negedge clk);
        n_tests++; if (w2_dat_o !== 32'd0) begin n_fail++; $display("FAIL wrap_dat_idle: got %h want 0", w2_dat_o); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (w2_mvalid !== 1'b1 || {w2_mlast, w2_mdata} !== {(i == 3), 4'hF, data[i]}) begin
                n_fail++; $display("FAIL wrap_entry[%0d]: v=%b got %h want %h", i, w2_mvalid, {w2_mlast, w2_mdata}, {(i == 3), 4'hF, data[i]});
            end
            w2_mready = 1'b1;
            @(negedge clk);
        end
        w2_mready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst();
        test_nonseq();
        test_backpressure();
        test_nonhit_status();
        test_reset_mid();
        test_random();
        test_addr_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_dma_burst_capture.md
WB_DMA_BURST_CAPTURE -- requirements
Module: wb_dma_burst_capture

Interface
REQ-001 Parameter BASE_ADR, default 32'h3000_0000, window base address matched by the block.
REQ-002 Parameter ADR_MASK, default 32'hFFFF_0000, mask applied to wbs_adr_i and BASE_ADR for the window compare.
REQ-003 Parameter BURST_LEN, default 4, number of sequential beats that form one burst (2..16).
REQ-004 Parameter FIFO_DEPTH, default 8, capture FIFO entries (power of two, >= BURST_LEN).
REQ-005 wb_clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 wb_rst_i  in  1  synchronous, active-high reset.
REQ-007 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-008 wbs_sel_i  in  4  byte enables, stored with the data.
REQ-009 wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
REQ-010 wbs_ack_o  out  1  transfer acknowledge.
REQ-011 wbs_dat_o  out  32  read data (status word).
REQ-012 dma_brust_valid  out  1  one-cycle pulse when a burst completes.
REQ-013 m_valid, m_ready  out/in  1 each  capture stream handshake.
REQ-014 m_data  out  36  {sel[3:0], data[31:0]} of the head entry.
REQ-015 m_last  out  1  head entry is the final beat of a burst.

Function
REQ-016 A hit is cyc&stb with (wbs_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK); non-hits are never acked and change no state.
REQ-017 Slave FSM states: IDLE, ACK; IDLE->ACK on an accepted hit, ACK->IDLE unconditionally; wbs_ack_o is 1 only in ACK (exactly one cycle).
REQ-018 A write hit in IDLE is accepted only if the FIFO is not full at that edge; otherwise the FSM stays in IDLE (ack withheld) until space appears.
REQ-019 Full is evaluated before any same-cycle pop; a pop never frees space for a push in the same cycle.
REQ-020 An accepted write pushes {wbs_sel_i, wbs_dat_i} at the accepting edge; the entry is visible on m_* one cycle later at the earliest.
REQ-021 A read hit in IDLE is always accepted; wbs_dat_o in ACK = {16'd0, fifo_level[7:0], 3'd0, beat_cnt[4:0]}; wbs_dat_o is 0 outside ACK.
REQ-022 Beat counter beat_cnt (5 bits) updates only on accepted writes: set to 1 if beat_cnt == 0 or wbs_adr_i != last_adr + 4 (32-bit wrap), else incremented; last_adr is loaded with wbs_adr_i.
REQ-023 When the update would make beat_cnt == BURST_LEN, that entry is pushed with last=1, beat_cnt returns to 0, and dma_brust_valid pulses high in the same cycle as that beat's ack.
REQ-024 A non-sequential beat abandons the partial burst without a pulse; entries already pushed keep last=0.
REQ-025 Stream pop occurs when m_valid & m_ready; m_valid = FIFO not empty; m_data/m_last are the head entry and are held stable while m_valid & !m_ready.
REQ-026 Reads do not affect beat_cnt, last_adr or the FIFO.

Reset
REQ-027 While wb_rst_i is high at an edge: FSM to IDLE, FIFO emptied, beat_cnt = 0, last_adr = 0.
REQ-028 Output values after reset: wbs_ack_o 0, wbs_dat_o 0, dma_brust_valid 0, m_valid 0, m_last 0, m_data 0.
REQ-029 Reset mid-transaction drops any pending ack; the master's cycle stays unacknowledged until re-accepted after reset release.

Structure
REQ-030 Package wb_dma_burst_pkg holds the FSM state enum, the status-word field offsets and the entry width constant (36).
REQ-031 The FIFO is a sub-module wb_dma_burst_fifo (synchronous, FIFO_DEPTH entries, 37-bit payload incl. last, full/empty/level outputs).

Verification
REQ-032 Writes to 0x3000_0000, _04, _08, _0C with data 1..4 -> four acks one cycle after stb; dma_brust_valid pulses with the 4th ack; stream outputs 1,2,3,4 with m_last only on 4.
REQ-033 Writes to 0x3000_0000, _04, then 0x3000_0020 -> no pulse; beat_cnt reads back 1; all three entries have m_last=0.
REQ-034 m_ready=0, nine sequential writes -> first eight acked, ninth ack withheld; raising m_ready for one pop -> ninth acked exactly one cycle after the pop edge.
REQ-035 Write to 0x3001_0000 -> no ack, FIFO level 0; read of 0x3000_0000 after two buffered writes -> wbs_dat_o = 0x0000_0200.
REQ-036 Assert wb_rst_i in the cycle an ack is due with 3 entries buffered -> ack stays 0, m_valid 0, status read after release = 0.
REQ-037 Sequential writes 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004 with ADR_MASK = 0 -> wrap counted sequential; one dma_brust_valid pulse.
